// File: rtl/cluster_event_rx_if.sv
// ---------------------------------------------------------------------------
// cluster_event_rx_if : SoC->cluster event bus (token FIFO + event stream)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cluster_event_rx_if #(
    parameter int BUFFER_WIDTH = 8,
    parameter int EVNT_WIDTH   = 8
);
    logic [BUFFER_WIDTH-1:0]            events_wt;
    logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da;
    logic [BUFFER_WIDTH-1:0]            events_rp;
    logic                               evt_valid;
    logic [EVNT_WIDTH-1:0]              evt_data;
    logic                               evt_ready;
    logic [15:0]                        evt_count;

    // master: writer + consumer side; slave: the reader block
    modport master (
        output events_wt, events_da, evt_ready,
        input  events_rp, evt_valid, evt_data, evt_count
    );

    modport slave (
        input  events_wt, events_da, evt_ready,
        output events_rp, evt_valid, evt_data, evt_count
    );
endinterface

`default_nettype wire

// File: rtl/cluster_event_rx.sv
// ---------------------------------------------------------------------------
// cluster_event_rx : cluster-side reader of the token/read-pointer event FIFO.
// Optional delivered-event counter: CLUSTER_EVENT_RX_STATS_EN. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cluster_event_rx #(
    parameter int BUFFER_WIDTH = 8,
    parameter int EVNT_WIDTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    cluster_event_rx_if.slave bus
);
    localparam int IDX_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUFFER_WIDTH - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] wt_s;
    logic [BUFFER_WIDTH-1:0] rp_q;
    logic [IDX_W-1:0]        idx;
    logic [EVNT_WIDTH-1:0]   data_q;
    logic [EVNT_WIDTH-1:0]   slot [BUFFER_WIDTH];
    logic                    avail;
    logic                    pop;

    // Per-bit synchroniser is safe: the writer changes only one token bit per write.
    generate
        for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
            if (s == 0) begin : g_first
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) sync_q[s] <= '0;
                    else       sync_q[s] <= bus.events_wt;
                end
            end else begin : g_next
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) sync_q[s] <= '0;
                    else       sync_q[s] <= sync_q[s-1];
                end
            end
        end

        for (genvar i = 0; i < BUFFER_WIDTH; i++) begin : g_slot
            assign slot[i] = bus.events_da[i*EVNT_WIDTH +: EVNT_WIDTH];
        end
    endgenerate

    assign wt_s  = sync_q[SYNC_STAGES-1];
    assign avail = (wt_s[idx] != rp_q[idx]);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            EMPTY: begin
                if (avail) begin
                    pop       = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (bus.evt_ready) begin
                    if (avail) pop       = 1'b1;
                    else       state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= EMPTY;
            rp_q   <= '0;
            idx    <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                rp_q[idx] <= ~rp_q[idx];
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                data_q    <= slot[idx];
            end
        end
    end

    assign bus.events_rp = rp_q;
    assign bus.evt_valid = (state == FULL);
    assign bus.evt_data  = data_q;

`ifdef CLUSTER_EVENT_RX_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                               count_q <= '0;
        else if (bus.evt_valid && bus.evt_ready) count_q <= count_q + 16'd1;
    end

    assign bus.evt_count = count_q;
`else
    assign bus.evt_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cluster_event_rx.sv
// ---------------------------------------------------------------------------
// tb_cluster_event_rx : self-checking bench for cluster_event_rx.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cluster_event_rx;
    logic clk;
    logic rst;
    logic ready;
    logic [7:0]      wt;
    logic [7:0][7:0] da;
    int              wi;
    logic [7:0]      expq[$];
    int checks;
    int errors;

    cluster_event_rx_if #(.BUFFER_WIDTH(8), .EVNT_WIDTH(8)) bus ();

    cluster_event_rx #(.BUFFER_WIDTH(8), .EVNT_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign bus.events_wt = wt;
    assign bus.events_da = da;
    assign bus.evt_ready = ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wt = '0; wi = 0; ready = 1'b0; expq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit can_write();
        return wt[wi] == bus.events_rp[wi];
    endfunction

    task automatic push_word(input logic [7:0] v);
        da[wi] = v;
        wt[wi] = ~wt[wi];
        expq.push_back(v);
        wi = (wi + 1) % 8;
    endtask

    task automatic test_reset();
        rst = 1'b0; wt = '0; da = '0; ready = 1'b0; wi = 0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.evt_valid !== 1'b0 || bus.events_rp !== 8'h00 || bus.evt_data !== 8'h00 || bus.evt_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: valid=%b rp=%h data=%h count=%h expected 0", bus.evt_valid, bus.events_rp, bus.evt_data, bus.evt_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bus.evt_valid !== 1'b0 || bus.events_rp !== 8'h00) begin
                errors++;
                $display("FAIL idle: cycle %0d valid=%b rp=%h expected 0/00", c, bus.evt_valid, bus.events_rp);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b1;
        da[0] = 8'hA5;
        wt[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            checks++;
            if (e == 3) begin
                if (bus.evt_valid !== 1'b1 || bus.evt_data !== 8'hA5 || bus.events_rp !== 8'h01) begin
                    errors++;
                    $display("FAIL single_latency: edge3 valid=%b data=%h rp=%h expected 1/a5/01", bus.evt_valid, bus.evt_data, bus.events_rp);
                end
            end else if (bus.evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_valid: edge %0d valid=%b expected 0", e, bus.evt_valid);
            end
        end
    endtask

    task automatic test_burst();
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) da[i] = 8'h10 + 8'(i);
        wt = 8'hFF;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.evt_valid !== 1'b1 || bus.evt_data !== 8'h10 + 8'(k)) begin
                errors++;
                $display("FAIL burst_word: k=%0d valid=%b data=%h expected 1/%h", k, bus.evt_valid, bus.evt_data, 8'h10 + 8'(k));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus.evt_valid !== 1'b0 || bus.events_rp !== 8'hFF) begin
            errors++;
            $display("FAIL burst_end: valid=%b rp=%h expected 0/ff", bus.evt_valid, bus.events_rp);
        end
        @(negedge clk);
        da[0] = 8'h20;
        wt = 8'hFE;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.evt_valid !== 1'b1 || bus.evt_data !== 8'h20 || bus.events_rp !== 8'hFE) begin
            errors++;
            $display("FAIL burst_wrap: valid=%b data=%h rp=%h expected 1/20/fe", bus.evt_valid, bus.evt_data, bus.events_rp);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        da[0] = 8'h31; da[1] = 8'h32; da[2] = 8'h33;
        wt = 8'h07;
        repeat (3) @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.evt_valid !== 1'b1 || bus.evt_data !== 8'h31 || bus.events_rp !== 8'h01) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b data=%h rp=%h expected 1/31/01", c, bus.evt_valid, bus.evt_data, bus.events_rp);
            end
        end
        ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.evt_valid !== 1'b1 || bus.evt_data !== 8'h32 || bus.events_rp !== 8'h03) begin
            errors++;
            $display("FAIL bp_release1: valid=%b data=%h rp=%h expected 1/32/03", bus.evt_valid, bus.evt_data, bus.events_rp);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.evt_valid !== 1'b1 || bus.evt_data !== 8'h33 || bus.events_rp !== 8'h07) begin
            errors++;
            $display("FAIL bp_release2: valid=%b data=%h rp=%h expected 1/33/07", bus.evt_valid, bus.evt_data, bus.events_rp);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid=%b expected 0", bus.evt_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) da[i] = 8'h40 + 8'(i);
        wt = 8'hFF;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.events_rp == 8'h0F) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_reach: rp=%h expected 0f within 20 cycles", bus.events_rp);
        end
        #2 rst = 1'b1;
        wt = '0; wi = 0; expq.delete();
        #1;
        checks++;
        if (bus.events_rp !== 8'h00 || bus.evt_valid !== 1'b0 || bus.evt_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_clear: rp=%h valid=%b data=%h expected 00/0/00", bus.events_rp, bus.evt_valid, bus.evt_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_word(8'h5A);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.evt_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || bus.evt_data !== 8'h5A || bus.events_rp !== 8'h01) begin
            errors++;
            $display("FAIL midrst_fresh: seen=%b data=%h rp=%h expected 1/5a/01", seen, bus.evt_data, bus.events_rp);
        end
    endtask

    task automatic test_random();
        bit         hold;
        logic [7:0] hold_data;
        logic [15:0] cnt;
        logic [7:0] exp;
        do_reset();
        hold = 1'b0; hold_data = '0; cnt = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (bus.evt_valid !== 1'b1 || bus.evt_data !== hold_data) begin
                    errors++;
                    $display("FAIL rand_hold: cycle %0d valid=%b data=%h expected 1/%h", c, bus.evt_valid, bus.evt_data, hold_data);
                end
            end
            checks++;
`ifdef CLUSTER_EVENT_RX_STATS_EN
            if (bus.evt_count !== cnt) begin
`else
            if (bus.evt_count !== 16'h0) begin
`endif
                errors++;
                $display("FAIL rand_count: cycle %0d count=%h model=%h", c, bus.evt_count, cnt);
            end
            ready = ($urandom_range(0, 3) != 0);
            if (can_write() && $urandom_range(0, 2) != 0) push_word(8'($urandom));
            if (bus.evt_valid === 1'b1 && ready) begin
                checks++;
                exp = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                if (bus.evt_data !== exp) begin
                    errors++;
                    $display("FAIL rand_data: cycle %0d data=%h expected %h", c, bus.evt_data, exp);
                end
                cnt = cnt + 16'd1;
            end
            hold = (bus.evt_valid === 1'b1) && !ready;
            hold_data = bus.evt_data;
        end
        @(negedge clk);
        ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (bus.evt_valid === 1'b1) begin
                checks++;
                exp = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                if (bus.evt_data !== exp) begin
                    errors++;
                    $display("FAIL drain_data: data=%h expected %h", bus.evt_data, exp);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (expq.size() != 0 || bus.events_rp !== wt || bus.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: left=%0d rp=%h wt=%h valid=%b expected 0/equal/0", expq.size(), bus.events_rp, wt, bus.evt_valid);
        end
    endtask

`ifdef CLUSTER_EVENT_RX_STATS_EN
    task automatic test_count_wrap();
        int hs;
        int pushed;
        do_reset();
        ready = 1'b1;
        hs = 0; pushed = 0;
        for (int c = 0; c < 80000 && hs < 65537; c++) begin
            @(negedge clk);
            if (bus.evt_valid === 1'b1) hs++;
            if (pushed < 65537 && can_write()) begin
                da[wi] = 8'(pushed);
                wt[wi] = ~wt[wi];
                wi = (wi + 1) % 8;
                pushed++;
            end
        end
        @(posedge clk); #1;
        ready = 1'b0;
        checks++;
        if (hs != 65537 || bus.evt_count !== 16'h0001) begin
            errors++;
            $display("FAIL count_wrap: handshakes=%0d count=%h expected 65537/0001", hs, bus.evt_count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef CLUSTER_EVENT_RX_STATS_EN
        test_count_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
